// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory arbiter slice.
package mem_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 8;

  // Requester indices into the packed request/response vectors.
  localparam int REQ_CPU = 0;
  localparam int REQ_DMA = 1;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin picker with its registered priority pointer.
// The pointer names the requester that wins the next tie.
module rr_arbiter_2
  import mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic r_rr;

  // Single requester wins outright; a tie goes to the pointer.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = r_rr ? 2'b10 : 2'b01;
    end
  end

  // After a grant the loser of that grant gets priority next time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr <= 1'b0;
    end else if (advance) begin
      r_rr <= grant[REQ_CPU];
    end
  end

endmodule

// File: rtl/mem_arbiter_2req.sv
// Shares one single-port data memory between the CPU LSU and the
// loader/debug DMA: round-robin grants, optional bounded burst lock,
// one-cycle registered read responses.
//
//   state      | meaning
//   ARB_IDLE   | round-robin between both requesters
//   ARB_LOCKED | only the lock owner may be granted; busy=1
module mem_arbiter_2req
  import mem_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int BURST_MAX = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [1:0]            req_lock,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  // Count of the beat that ends a full-length burst.
  localparam logic [7:0] LP_LAST_BEAT = 8'(BURST_MAX - 1);
  localparam bit         LP_LOCK_EN   = (BURST_MAX > 1);

  arb_state_t        r_state, w_state_nxt;
  logic              r_owner, w_owner_nxt;
  logic [7:0]        r_count, w_count_nxt;
  logic [1:0]        r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [1:0]        w_req_elig;
  logic [1:0]        w_grant;
  logic              w_xfer;
  logic              w_win;

  // Reset blocks all grants; a held lock masks off the non-owner.
  always_comb begin
    w_req_elig = req_valid;
    if (rst) begin
      w_req_elig = 2'b00;
    end else if (r_state == ARB_LOCKED) begin
      w_req_elig = req_valid & (r_owner ? 2'b10 : 2'b01);
    end
  end

  rr_arbiter_2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req_elig),
    .advance (w_xfer),
    .grant   (w_grant)
  );

  assign w_xfer    = |w_grant;
  assign w_win     = w_grant[REQ_DMA];
  assign req_ready = w_grant;

  // Steer the winner onto the memory; park the bus at address 0 when idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_xfer) begin
      mem_we    = req_we[w_win];
      mem_addr  = req_addr[w_win*ADDR_W +: ADDR_W];
      mem_wdata = req_wdata[w_win*DATA_W +: DATA_W];
    end
  end

  // Lock FSM next state. Leaving LOCKED needs no pointer fix-up: every
  // owner grant already pointed rr at the other requester.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_count_nxt = r_count;
    case (r_state)
      ARB_IDLE: begin
        if (LP_LOCK_EN && w_xfer && req_lock[w_win]) begin
          w_state_nxt = ARB_LOCKED;
          w_owner_nxt = w_win;
          w_count_nxt = 8'd1;
        end
      end
      ARB_LOCKED: begin
        if (!req_valid[r_owner]) begin
          w_state_nxt = ARB_IDLE;
          w_count_nxt = 8'd0;
        end else if (w_xfer) begin
          if (!req_lock[r_owner] || (r_count == LP_LAST_BEAT)) begin
            w_state_nxt = ARB_IDLE;
            w_count_nxt = 8'd0;
          end else begin
            w_count_nxt = r_count + 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_count_nxt = 8'd0;
      end
    endcase
  end

  // Lock FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_owner <= 1'b0;
      r_count <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Capture read data at the accepting edge; response lasts one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 2'b00;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_grant & ~req_we;
      if (w_xfer && !req_we[w_win]) begin
        r_rsp_rdata <= mem_rdata;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign busy      = (r_state == ARB_LOCKED);

endmodule
